// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM loader: controller states and download address width.
package ram_loader_pkg;

    localparam int DL_ADDR_W = 25;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/ram_loader_if.sv
// Bundle of the ioctl download, CPU bus, RAM port A and status signals around the loader.
interface ram_loader_if
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) ();

    logic                 dl_active;
    logic                 dl_wr;
    logic [DL_ADDR_W-1:0] dl_addr;
    logic [DATA_W-1:0]    dl_data;
    logic                 dl_wait;

    logic                 cpu_we;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [DATA_W-1:0]    cpu_din;
    logic                 cpu_stall;

    logic                 ram_wren;
    logic [ADDR_W-1:0]    ram_addr;
    logic [DATA_W-1:0]    ram_data;

    logic                 busy;
    logic                 overflow;
    logic [ADDR_W:0]      load_count;

    // Core side: drives downloads and CPU accesses, observes RAM port A and status.
    modport master (
        output dl_active, dl_wr, dl_addr, dl_data,
        output cpu_we, cpu_addr, cpu_din,
        input  dl_wait, cpu_stall,
        input  ram_wren, ram_addr, ram_data,
        input  busy, overflow, load_count
    );

    // Loader side.
    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data,
        input  cpu_we, cpu_addr, cpu_din,
        output dl_wait, cpu_stall,
        output ram_wren, ram_addr, ram_data,
        output busy, overflow, load_count
    );

endinterface

// File: rtl/ram_loader_hold.sv
// One-deep holding register for download bytes; a full slot always drains on the next cycle.
module ram_loader_hold
    import ram_loader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_wr,
    input  logic [DL_ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0]    i_data,
    output logic                 o_valid,
    output logic [DL_ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0]    o_data,
    output logic                 o_drop
);

    logic                 r_valid;
    logic [DL_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]    r_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            // The owner consumes the held byte this cycle; a new strobe now is dropped.
            r_valid <= 1'b0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_drop  = r_valid && i_wr;

endmodule

// File: rtl/ram_loader.sv
// Port A front end of the block RAM: clears it after reset, loads ioctl downloads,
// and otherwise passes CPU accesses straight through.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int                   ADDR_W     = 10,
    parameter int                   DATA_W     = 8,
    parameter logic [DL_ADDR_W-1:0] BASE       = '0,
    parameter logic [DATA_W-1:0]    FILL_VALUE = '0
) (
    input  logic        clock,
    input  logic        reset,
    ram_loader_if.slave bus
);

    localparam logic [ADDR_W-1:0] CLR_LAST  = '1;
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t        r_state;
    logic [ADDR_W-1:0]    r_clr_addr;
    logic                 r_overflow;
    logic [ADDR_W:0]      r_load_count;

    logic                 w_accept_wr;
    logic                 w_hold_v;
    logic [DL_ADDR_W-1:0] w_hold_a;
    logic [DATA_W-1:0]    w_hold_d;
    logic                 w_drop;
    logic [DL_ADDR_W-1:0] w_off;
    logic                 w_in_range;
    logic                 w_load_exit;

    // A strobe coinciding with dl_active rising in IDLE is caught too, so no byte is lost.
    assign w_accept_wr = bus.dl_wr &&
                         ((r_state == LOAD) || ((r_state == IDLE) && bus.dl_active));

    ram_loader_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clock   (clock),
        .reset   (reset),
        .i_wr    (w_accept_wr),
        .i_addr  (bus.dl_addr),
        .i_data  (bus.dl_data),
        .o_valid (w_hold_v),
        .o_addr  (w_hold_a),
        .o_data  (w_hold_d),
        .o_drop  (w_drop)
    );

    assign w_off       = w_hold_a - BASE;
    assign w_in_range  = (w_hold_a >= BASE) && (w_off[DL_ADDR_W-1:ADDR_W] == '0);
    // Staying while a late strobe is latched guarantees every accepted byte is written.
    assign w_load_exit = !bus.dl_active && !w_hold_v && !bus.dl_wr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= CLEAR;
            r_clr_addr   <= '0;
            r_overflow   <= 1'b0;
            r_load_count <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_addr <= r_clr_addr + 1'b1;
                    if (r_clr_addr == CLR_LAST) begin
                        r_state      <= bus.dl_active ? LOAD : IDLE;
                        r_overflow   <= 1'b0;
                        r_load_count <= '0;
                    end
                end
                IDLE: begin
                    if (bus.dl_active) begin
                        r_state      <= LOAD;
                        r_overflow   <= 1'b0;
                        r_load_count <= '0;
                    end
                end
                LOAD: begin
                    if (w_hold_v && w_in_range && (r_load_count != COUNT_MAX)) begin
                        r_load_count <= r_load_count + 1'b1;
                    end
                    if ((w_hold_v && !w_in_range) || w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_load_exit) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    always_comb begin
        bus.ram_wren = 1'b0;
        bus.ram_addr = '0;
        bus.ram_data = '0;
        case (r_state)
            CLEAR: begin
                bus.ram_wren = 1'b1;
                bus.ram_addr = r_clr_addr;
                bus.ram_data = FILL_VALUE;
            end
            IDLE: begin
                bus.ram_wren = bus.cpu_we;
                bus.ram_addr = bus.cpu_addr;
                bus.ram_data = bus.cpu_din;
            end
            LOAD: begin
                bus.ram_wren = w_hold_v && w_in_range;
                bus.ram_addr = w_off[ADDR_W-1:0];
                bus.ram_data = w_hold_d;
            end
            default: begin
                bus.ram_wren = 1'b0;
            end
        endcase
        // Nothing reaches the RAM while reset is held, whatever state it interrupted.
        if (reset) begin
            bus.ram_wren = 1'b0;
        end
    end

    assign bus.dl_wait    = reset || (r_state == CLEAR) || w_hold_v;
    assign bus.cpu_stall  = reset || (r_state != IDLE);
    assign bus.busy       = reset || (r_state != IDLE);
    assign bus.overflow   = r_overflow;
    assign bus.load_count = r_load_count;

endmodule

// File: doc/ram_loader.md
# ram_loader

Write-side front end for the dual-port block RAM; it owns RAM port A. After reset it fills the whole RAM with a constant. During an HPS download (ioctl) it writes the incoming byte stream into the RAM. Otherwise it passes CPU accesses straight through. It sits between the core's CPU bus / ioctl interface and port A of the RAM; port B is untouched.

## Interface
Parameters:
- ADDR_W, 10, RAM address width; must equal the RAM's address width.
- DATA_W, 8, data width.
- BASE, 0, download address that maps to RAM word 0.
- FILL_VALUE, 0, word written to every location during clear.

Ports:
- clock  in  1  single core clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- dl_active  in  1  download in progress (ioctl_download).
- dl_wr  in  1  one-cycle strobe: byte valid.
- dl_addr  in  25  download byte address.
- dl_data  in  DATA_W  download byte.
- dl_wait  out  1  upstream must hold dl_wr low while this is high.
- cpu_we  in  1  CPU write strobe.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_din  in  DATA_W  CPU write data.
- cpu_stall  out  1  CPU access not serviced this cycle.
- ram_wren  out  1  to RAM port A write enable.
- ram_addr  out  ADDR_W  to RAM port A address.
- ram_data  out  DATA_W  to RAM port A write data.
- busy  out  1  high in CLEAR or LOAD.
- overflow  out  1  sticky: a download byte fell outside the RAM.
- load_count  out  ADDR_W+1  bytes written in the current/last download.

## Operation
- States: CLEAR, IDLE, LOAD.
- **CLEAR**
  - Entered on reset. clr_addr counts 0 to 2^ADDR_W-1.
  - Each cycle: ram_wren=1, ram_addr=clr_addr, ram_data=FILL_VALUE.
  - After the last address, go to IDLE, or to LOAD if dl_active=1.
- **IDLE**
  - Combinational passthrough: ram_wren=cpu_we, ram_addr=cpu_addr, ram_data=cpu_din.
  - dl_active=1 moves to LOAD next cycle, clears overflow and load_count.
- **LOAD**
  - Holding register hold_v/hold_a/hold_d, one deep.
  - dl_wr with hold empty latches the byte.
  - The next cycle issues the write: off = dl_addr - BASE.
    - If 0 <= off < 2^ADDR_W: ram_wren=1, ram_addr=off[ADDR_W-1:0], load_count+1.
    - Otherwise: no write, overflow set.
  - If dl_wr arrives while hold is full (protocol violation), the byte is dropped and overflow is set.
  - Leaves to IDLE on the first cycle with dl_active=0 and hold empty. A held byte is always written before exit.
- **Outputs by state**
  - cpu_stall = 1 in CLEAR and LOAD, 0 in IDLE.
  - dl_wait = 1 in CLEAR or when hold is full.
  - busy = (state != IDLE).
- **Arithmetic**
  - The off subtraction is 25-bit unsigned; dl_addr < BASE counts as out of range.
  - load_count saturates at 2^ADDR_W.

## Timing
- **During reset:**
  - state=CLEAR, clr_addr=0, hold empty, overflow=0, load_count=0.
  - ram_wren=0, busy=1, dl_wait=1, cpu_stall=1.
- **Clear:**
  - The first fill write is in the first cycle after reset deasserts.
  - The clear takes exactly 2^ADDR_W cycles (1024 at default).
  - IDLE is reached in cycle 2^ADDR_W+1.
- **Download write latency:** 1 cycle (dl_wr at cycle t, ram_wren at t+1).
  - Sustained rate is one byte per 2 cycles: hold is full at t+1, so dl_wait is high there.
- **CPU passthrough:** 0 cycles (same-cycle to the RAM inputs).
- **Reset mid-operation:** restarts CLEAR from address 0. Any held byte is discarded; overflow and load_count are cleared.
- **dl_active during CLEAR:** not acted on until CLEAR finishes; dl_wait stays high the whole time.

## Structure
- Shared package (core's common pkg):
  - state enum loader_state_t {CLEAR, IDLE, LOAD}.
  - localparam DL_ADDR_W = 25.
- Single module, no sub-modules.
- Optional sub-module ram_loader_hold for the one-deep holding register if reused for other download targets.

## Test plan
- **Reset, 2 cycles, then release:**
  - ram_wren=1 with addr 0,1,…,1023 and data 0 on consecutive cycles.
  - busy falls in cycle 1025.
  - A RAM read-back of addr 0, 512 and 1023 returns 0.
- **IDLE, cpu_we=1, cpu_addr=0x155, cpu_din=0xA5:** same cycle ram_wren=1, ram_addr=0x155, ram_data=0xA5, cpu_stall=0.
- **BASE=0x2000, dl_active, 4 bytes at 0x2000..0x2003 (0x11..0x44), each strobed only when dl_wait=0:**
  - RAM words 0..3 = 0x11..0x44.
  - load_count=4, overflow=0.
  - Return to IDLE one cycle after dl_active falls.
- **Download byte at dl_addr=0x1FFF, then one at 0x2400 (BASE=0x2000):** no RAM writes, overflow=1, load_count=0.
- **Back-to-back dl_wr on cycles t and t+1:** the t+1 byte is dropped, overflow=1, only one write occurs.
- **dl_active asserted at clear cycle 100:** no download write before clear completes; dl_wait=1 throughout; LOAD entered directly after clear. Reset pulsed mid-LOAD: clear restarts at addr 0.
